// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: the first requester after last_grant
// (wrapping modulo NUM_CH) wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // Offsets 1..NUM_CH visit every channel once, last_grant itself last.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!grant_valid && req[idx[SEL_W-1:0]]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with manual or round-robin selection and
// a single registered output stage running at one word per cycle.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_ch
);

  mux_mode_t         mode_e;
  logic              can_load;
  logic              gvalid;
  logic              rr_valid;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  rr_grant;

  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic [SEL_W-1:0]  out_ch_q,     out_ch_d;
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;

  assign mode_e = mux_mode_t'(mode);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req         (in_valid),
    .last_grant  (last_grant_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // Grant selection; ready is suppressed during reset so no handshake completes.
  always_comb begin
    grant    = sel;
    gvalid   = 1'b0;
    can_load = !out_valid_q || out_ready;
    in_ready = '0;
    if (mode_e == MODE_RR) begin
      grant  = rr_grant;
      gvalid = rr_valid;
    end else if (int'(sel) < NUM_CH) begin
      gvalid = in_valid[sel];
    end
    if (rst_n && can_load && gvalid) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (can_load && gvalid) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant)*DATA_W +: DATA_W];
      out_ch_d    = grant;
      if (mode_e == MODE_RR) begin
        last_grant_d = grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Reset leaves last_grant at the top channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, hand-written
// fairness sequences, then random traffic against a behavioural model.
module tb_stream_mux_rr;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;
  localparam logic [31:0] FIXED_DATA = 32'h44A52211;

  logic                     clk;
  logic                     rst_n;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEL_W-1:0]         out_ch;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_valid = 1'b0;
  logic [7:0]  m_data  = 8'h00;
  int          m_ch    = 0;
  int          m_last  = NUM_CH - 1;
  logic        m_gok   = 1'b0;
  int          m_g     = 0;
  logic [3:0]  m_ready = 4'b0;

  typedef struct packed {
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] in_valid;
    logic       out_ready;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[$];

  stream_mux_rr #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                              input logic [3:0] v, input logic o, input logic [3:0] er,
                              input logic ev, input logic [7:0] ed, input logic [1:0] ec);
    vec_t t;
    t.rst_n = r; t.mode = m; t.sel = s; t.in_valid = v; t.out_ready = o;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_ch = ec;
    return t;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then predict the grant from the model state.
  task automatic applyStimulus(input logic r, input logic m, input logic [1:0] s,
                               input logic [3:0] v, input logic o, input logic [31:0] d);
    int c;
    rst_n = r; mode = m; sel = s; in_valid = v; out_ready = o; in_data = d;
    #1;
    m_gok = 1'b0;
    m_g   = 0;
    if (!m) begin
      if (v[s]) begin m_gok = 1'b1; m_g = int'(s); end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (!m_gok && v[c]) begin m_gok = 1'b1; m_g = c; end
      end
    end
    m_ready = (r && (!m_valid || o) && m_gok) ? 4'(1 << m_g) : 4'b0;
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_last = NUM_CH - 1;
    end else if ((!m_valid || out_ready) && m_gok) begin
      m_valid = 1'b1;
      m_data  = 8'(in_data >> (8 * m_g));
      m_ch    = m_g;
      if (mode) m_last = m_g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  initial begin
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0));
    vecs.push_back(mk(1, 0, 2, 4'b1111, 1, 4'b0100, 1, 8'hA5, 2));
    vecs.push_back(mk(1, 0, 3, 4'b1111, 1, 4'b1000, 1, 8'h44, 3));
    vecs.push_back(mk(1, 0, 2, 4'b1011, 1, 4'b0000, 0, 8'h44, 3));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b0010, 1, 8'h22, 1));
    vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b0100, 1, 8'hA5, 2));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b0001, 1, 8'h11, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1, 8'h11, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 0, 4'b0000, 1, 8'h11, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b0010, 1, 8'h22, 1));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 0, 4'b0000, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 0, 4'b1010, 1, 4'b0010, 1, 8'h22, 1));
    vecs.push_back(mk(1, 1, 0, 4'b1010, 1, 4'b1000, 1, 8'h44, 3));
    vecs.push_back(mk(1, 1, 0, 4'b1010, 1, 4'b0010, 1, 8'h22, 1));
    vecs.push_back(mk(1, 1, 0, 4'b0000, 1, 4'b0000, 0, 8'h22, 1));
    vecs.push_back(mk(1, 0, 1, 4'b0010, 0, 4'b0010, 1, 8'h22, 1));
    vecs.push_back(mk(1, 0, 1, 4'b0010, 0, 4'b0000, 1, 8'h22, 1));

    $display("[TB] directed vector table, %0d rows", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].mode, vecs[i].sel, vecs[i].in_valid,
                    vecs[i].out_ready, FIXED_DATA);
      checkOutput($sformatf("row%0d in_ready", i), int'(in_ready), int'(vecs[i].exp_ready));
      clockEdge();
      checkOutput($sformatf("row%0d out_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
      checkOutput($sformatf("row%0d out_data", i), int'(out_data), int'(vecs[i].exp_data));
      checkOutput($sformatf("row%0d out_ch", i), int'(out_ch), int'(vecs[i].exp_ch));
    end

    $display("[TB] round-robin fairness sequence");
    applyStimulus(0, 1, 0, 4'b1111, 1, FIXED_DATA);
    clockEdge();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1, 0, 4'b1111, 1, FIXED_DATA);
      checkOutput($sformatf("rr%0d in_ready", k), int'(in_ready), 1 << (k % 4));
      clockEdge();
      checkOutput($sformatf("rr%0d out_valid", k), int'(out_valid), 1);
      checkOutput($sformatf("rr%0d out_ch", k), int'(out_ch), k % 4);
      checkOutput($sformatf("rr%0d out_data", k), int'(out_data),
                  int'(8'(FIXED_DATA >> (8 * (k % 4)))));
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 0, 4'b1010, 1, FIXED_DATA);
      clockEdge();
      checkOutput($sformatf("alt%0d out_ch", k), int'(out_ch), (k % 2 == 0) ? 1 : 3);
    end

    $display("[TB] random traffic against reference model");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), $urandom);
      checkOutput("rand in_ready", int'(in_ready), int'(m_ready));
      clockEdge();
      checkOutput("rand out_valid", int'(out_valid), int'(m_valid));
      checkOutput("rand out_data", int'(out_data), int'(m_data));
      checkOutput("rand out_ch", int'(out_ch), m_ch);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 stream multiplexer; successor to the combinational 2:1 mux.
- Selects one of NUM_CH valid/ready input channels and registers the selected word into a single output stage.
- Two selection modes:
  - Manual: an external select input picks the channel.
  - Round-robin: fair arbitration among the inputs that are currently valid.
- Sits between multiple producers and one consumer in the datapath.

Parameters:
- NUM_CH, 4, number of input channels (min 2).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(NUM_CH), width of sel and out_ch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mode  in  1  0 = manual select, 1 = round-robin.
- sel  in  SEL_W  channel index, used only when mode=0.
- in_data  in  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready (one-hot or zero).
- out_data  out  DATA_W  registered selected data.
- out_valid  out  1  output stage holds a word.
- out_ready  in  1  consumer accepts the word.
- out_ch  out  SEL_W  source channel index of out_data.

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - last_grant=NUM_CH-1, so channel 0 wins first in round-robin.
  - in_ready is all zero while rst_n is low.
- can_load = !out_valid || out_ready. The output stage accepts a new word in the same cycle the old one drains, giving full throughput of 1 word/cycle.
- Grant, combinational:
  - mode=0: grant=sel, gvalid=in_valid[sel]. If sel >= NUM_CH, there is no grant: gvalid=0 and in_ready=0.
  - mode=1: grant is the first i with in_valid[i]=1, searching from last_grant+1 upward and wrapping modulo NUM_CH. gvalid=|in_valid.
- in_ready[i] = can_load && gvalid && (i==grant). At most one bit is set. Ready may depend on valid; valid must not depend on ready.
- Load (can_load && gvalid at a clk edge):
  - out_data <= channel[grant], out_ch <= grant, out_valid <= 1.
  - In mode=1 only, last_grant <= grant.
- Drain without load (out_valid && out_ready && !gvalid): out_valid <= 0. out_data and out_ch hold their last values.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid are held stable; in_ready=0.
- Latency: 1 cycle from an input handshake to out_valid.
- Mode or sel changes:
  - Affect only the next load; a word already in the output stage is never altered.
  - Manual-mode transfers do not update last_grant.
- Reset mid-transfer: a pending output word is discarded and no handshake completes in that cycle.
- An input must hold data and valid until its handshake. The block does not check this.

Decomposition:
- Package stream_mux_pkg:
  - MODE_MANUAL=1'b0 and MODE_RR=1'b1 constants.
  - Typedef mux_mode_t.
- Sub-module rr_arbiter:
  - Parameter NUM_CH.
  - Inputs: req, last_grant. Outputs: grant index, grant_valid.
  - Purely combinational rotate-priority encoder.
- The top level holds the output register, the last_grant register and the mode/sel muxing.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_ch=0. Release -> first load in RR comes from channel 0.
- Manual mode: mode=0, sel=2, in_valid=1111, ch2 data=8'hA5, out_ready=1 -> in_ready=0100, next cycle out_data=A5 and out_ch=2. Then sel=3 -> next word from ch3. Then sel=2 with in_valid[2]=0 -> out_valid drops to 0 after the drain.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle. Then in_valid=1010 -> sequence alternates 1,3.
- Backpressure: mode=1, out_ready=0 for 4 cycles after the first load -> out_data and out_ch are stable, in_ready=0000, last_grant is unchanged. Raise out_ready -> the next channel loads in the same cycle as the drain.
- Mode switch mid-stream: RR grants ch1, then mode=0 with sel=0 -> next word from ch0. Return to mode=1 -> next grant is ch2, since last_grant is still 1.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and last_grant=3. After release, RR restarts at ch0.
